// File: rtl/answer_display_pkg.sv
// Shared display definitions: active-low hex font (bit0 = a ... bit6 = g),
// blank pattern and the scroller state encoding.
package answer_display_pkg;

    typedef enum logic {
        MANUAL = 1'b0,
        AUTO   = 1'b1
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Packed F..0 so HEX_FONT[n] is the glyph for nibble n.
    localparam logic [15:0][6:0] HEX_FONT = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/answer_window_scroller_button_conditioner.sv
// Raw button -> 2-flop synchronizer -> stable-level debounce -> one-cycle
// pulse on each accepted 0->1 transition.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic srst,
    input  logic raw,
    output logic pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_reg;
    logic             sync2_reg;
    logic             stable_reg;
    logic             pulse_reg;
    logic [CNT_W-1:0] count_reg;

    // The counter only runs while the synchronized level disagrees with the
    // accepted level, so any bounce back restarts the qualification window.
    always_ff @(posedge clk) begin
        if (srst) begin
            sync1_reg  <= 1'b0;
            sync2_reg  <= 1'b0;
            stable_reg <= 1'b0;
            pulse_reg  <= 1'b0;
            count_reg  <= '0;
        end else begin
            sync1_reg <= raw;
            sync2_reg <= sync1_reg;
            pulse_reg <= 1'b0;
            if (sync2_reg == stable_reg) begin
                count_reg <= '0;
            end else if (count_reg == CNT_LAST) begin
                stable_reg <= sync2_reg;
                pulse_reg  <= sync2_reg;
                count_reg  <= '0;
            end else begin
                count_reg <= count_reg + 1'b1;
            end
        end
    end

    assign pulse = pulse_reg;

endmodule

// File: rtl/answer_window_scroller.sv
// Scrolling WINDOW-digit view of a DIGITS-digit hex answer with manual/auto
// scrolling. Define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module answer_window_scroller
    import answer_display_pkg::*;
#(
    parameter int DIGITS          = 8,
    parameter int WINDOW          = 4,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int SCROLL_PERIOD   = 50000000
) (
    input  logic                  IN_clk,
    input  logic                  IN_reset,
    input  logic [4*DIGITS-1:0]   IN_binary_answer,
    input  logic                  IN_answer_valid,
    input  logic                  IN_up_button,
    input  logic                  IN_down_button,
    input  logic                  IN_center_button,
    output logic [7*WINDOW-1:0]   OUT_window_segs,
    output logic [DIGITS-1:0]     OUT_Led_Visualizer,
    output logic                  OUT_auto_mode
);

    localparam int OFF_W = $clog2(DIGITS);
    localparam int SCR_W = $clog2(SCROLL_PERIOD + 1);
    localparam logic [OFF_W-1:0] OFF_MAX = OFF_W'(DIGITS - WINDOW);
    localparam logic [SCR_W-1:0] SCR_TC  = SCR_W'(SCROLL_PERIOD - 1);
    localparam logic [DIGITS-1:0] LED_RESET = DIGITS'((64'd1 << WINDOW) - 64'd1);
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] LEAD_RESET = SEG_BLANK;
`else
    localparam logic [6:0] LEAD_RESET = HEX_FONT[0];
`endif

    logic [2:0] raw_buttons;
    logic [2:0] button_events;
    logic       up_ev;
    logic       down_ev;
    logic       center_ev;

    logic [4*DIGITS-1:0] answer_reg;
    state_t              state_reg, state_next;
    logic [OFF_W-1:0]    offset_reg, offset_next;
    logic [SCR_W-1:0]    scroll_reg, scroll_next;
    logic [7*WINDOW-1:0] segs_reg, segs_next;
    logic [DIGITS-1:0]   led_reg, led_next;

    assign raw_buttons = {IN_center_button, IN_down_button, IN_up_button};

    for (genvar gi = 0; gi < 3; gi++) begin : g_btn
        button_conditioner #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_btn (
            .clk  (IN_clk),
            .srst (IN_reset),
            .raw  (raw_buttons[gi]),
            .pulse(button_events[gi])
        );
    end

    assign up_ev     = button_events[0];
    assign down_ev   = button_events[1];
    assign center_ev = button_events[2];

    always_ff @(posedge IN_clk) begin
        if (IN_reset) begin
            answer_reg <= '0;
        end else if (IN_answer_valid) begin
            answer_reg <= IN_binary_answer;
        end
    end

    always_ff @(posedge IN_clk) begin
        if (IN_reset) begin
            state_reg  <= MANUAL;
            offset_reg <= '0;
            scroll_reg <= '0;
        end else begin
            state_reg  <= state_next;
            offset_reg <= offset_next;
            scroll_reg <= scroll_next;
        end
    end

    // Priority: center, then a lone up/down step, then the auto tick. Any
    // button event in a cycle suppresses the auto step for that cycle.
    always_comb begin
        state_next  = state_reg;
        offset_next = offset_reg;
        scroll_next = scroll_reg;
        if (center_ev) begin
            state_next  = (state_reg == MANUAL) ? AUTO : MANUAL;
            scroll_next = '0;
        end else if (up_ev && !down_ev) begin
            state_next  = MANUAL;
            scroll_next = '0;
            if (offset_reg != OFF_MAX) begin
                offset_next = offset_reg + 1'b1;
            end
        end else if (down_ev && !up_ev) begin
            state_next  = MANUAL;
            scroll_next = '0;
            if (offset_reg != '0) begin
                offset_next = offset_reg - 1'b1;
            end
        end else if (state_reg == AUTO && !(up_ev && down_ev)) begin
            if (scroll_reg == SCR_TC) begin
                scroll_next = '0;
                offset_next = (offset_reg == OFF_MAX) ? '0 : offset_reg + 1'b1;
            end else begin
                scroll_next = scroll_reg + 1'b1;
            end
        end
    end

    always_comb begin
        OUT_auto_mode = (state_reg == AUTO);
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [OFF_W-1:0] msd_idx;

    always_comb begin
        msd_idx = '0;
        for (int i = 1; i < DIGITS; i++) begin
            if (answer_reg[4*i +: 4] != 4'h0) begin
                msd_idx = OFF_W'(i);
            end
        end
    end
`endif

    for (genvar gi = 0; gi < WINDOW; gi++) begin : g_slot
        logic [OFF_W-1:0] digit_idx;
        logic [3:0]       nibble;

        assign digit_idx = offset_reg + OFF_W'(gi);
        assign nibble    = answer_reg[4*digit_idx +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        assign segs_next[7*gi +: 7] = (digit_idx > msd_idx) ? SEG_BLANK : HEX_FONT[nibble];
`else
        assign segs_next[7*gi +: 7] = HEX_FONT[nibble];
`endif
    end

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_led
        assign led_next[gi] = (gi >= int'(offset_reg)) && (gi < int'(offset_reg) + WINDOW);
    end

    always_ff @(posedge IN_clk) begin
        if (IN_reset) begin
            for (int i = 0; i < WINDOW; i++) begin
                segs_reg[7*i +: 7] <= (i == 0) ? HEX_FONT[0] : LEAD_RESET;
            end
            led_reg <= LED_RESET;
        end else begin
            segs_reg <= segs_next;
            led_reg  <= led_next;
        end
    end

    assign OUT_window_segs    = segs_reg;
    assign OUT_Led_Visualizer = led_reg;

endmodule

// File: tb/tb_answer_window_scroller.sv
// Directed bench for answer_window_scroller (DIGITS=8, WINDOW=4, short
// debounce and scroll periods); honours LEADING_ZERO_BLANK_EN if defined.
module tb_answer_window_scroller;

    logic        IN_clk = 1'b0;
    logic        IN_reset = 1'b1;
    logic [31:0] IN_binary_answer = '0;
    logic        IN_answer_valid = 1'b0;
    logic        IN_up_button = 1'b0;
    logic        IN_down_button = 1'b0;
    logic        IN_center_button = 1'b0;
    logic [27:0] OUT_window_segs;
    logic [7:0]  OUT_Led_Visualizer;
    logic        OUT_auto_mode;

    answer_window_scroller #(
        .DIGITS(8), .WINDOW(4), .DEBOUNCE_CYCLES(4), .SCROLL_PERIOD(10)
    ) dut (
        .IN_clk            (IN_clk),
        .IN_reset          (IN_reset),
        .IN_binary_answer  (IN_binary_answer),
        .IN_answer_valid   (IN_answer_valid),
        .IN_up_button      (IN_up_button),
        .IN_down_button    (IN_down_button),
        .IN_center_button  (IN_center_button),
        .OUT_window_segs   (OUT_window_segs),
        .OUT_Led_Visualizer(OUT_Led_Visualizer),
        .OUT_auto_mode     (OUT_auto_mode)
    );

    always #5 IN_clk = ~IN_clk;

    typedef struct {
        logic [31:0] answer;
        logic [27:0] exp_plain;
        logic [27:0] exp_blank;
    } vec_t;

    vec_t        vecs [6];
    int          checks = 0;
    int          errors = 0;
    logic [27:0] prev_segs;
    logic [27:0] rst_segs;
    logic [7:0]  exp_seq [7];
    logic [7:0]  prev_led;
    int          changes;
    int          last_cyc;

    function automatic logic [27:0] pick(input logic [27:0] plain, input logic [27:0] blank);
`ifdef LEADING_ZERO_BLANK_EN
        return blank;
`else
        return plain;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic press(input logic u, input logic d, input logic c, input int hold, input int post);
        IN_up_button = u;
        IN_down_button = d;
        IN_center_button = c;
        repeat (hold) @(negedge IN_clk);
        IN_up_button = 1'b0;
        IN_down_button = 1'b0;
        IN_center_button = 1'b0;
        repeat (post) @(negedge IN_clk);
        $display("press up=%0b down=%0b center=%0b hold=%0d -> led=%h auto=%0b segs=%h",
                 u, d, c, hold, OUT_Led_Visualizer, OUT_auto_mode, OUT_window_segs);
    endtask

    initial begin
        // Slots 3..0 at offset 0.
        vecs[0] = '{32'h0000_00A5, {7'h40, 7'h40, 7'h08, 7'h12}, {7'h7F, 7'h7F, 7'h08, 7'h12}};
        vecs[1] = '{32'h0000_0000, {7'h40, 7'h40, 7'h40, 7'h40}, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
        vecs[2] = '{32'h89EF_0567, {7'h40, 7'h12, 7'h02, 7'h78}, {7'h40, 7'h12, 7'h02, 7'h78}};
        vecs[3] = '{32'h0000_3F00, {7'h30, 7'h0E, 7'h40, 7'h40}, {7'h30, 7'h0E, 7'h40, 7'h40}};
        vecs[4] = '{32'h0000_0102, {7'h40, 7'h79, 7'h40, 7'h24}, {7'h7F, 7'h79, 7'h40, 7'h24}};
        vecs[5] = '{32'h1234_ABCD, {7'h08, 7'h03, 7'h46, 7'h21}, {7'h08, 7'h03, 7'h46, 7'h21}};
        exp_seq = '{8'h1E, 8'h3C, 8'h78, 8'hF0, 8'h0F, 8'h1E, 8'h3C};
        rst_segs = pick({7'h40, 7'h40, 7'h40, 7'h40}, {7'h7F, 7'h7F, 7'h7F, 7'h40});

        repeat (3) @(negedge IN_clk);
        check("reset_segs", 32'(OUT_window_segs), 32'(rst_segs));
        check("reset_led", 32'(OUT_Led_Visualizer), 32'h0F);
        check("reset_auto", 32'(OUT_auto_mode), 32'h0);
        IN_reset = 1'b0;
        @(negedge IN_clk);

        prev_segs = rst_segs;
        for (int i = 0; i < 6; i++) begin
            IN_binary_answer = vecs[i].answer;
            IN_answer_valid = 1'b1;
            @(negedge IN_clk);
            IN_answer_valid = 1'b0;
            check("load_lat1", 32'(OUT_window_segs), 32'(prev_segs));
            @(negedge IN_clk);
            check("load_segs", 32'(OUT_window_segs), 32'(pick(vecs[i].exp_plain, vecs[i].exp_blank)));
            check("load_led", 32'(OUT_Led_Visualizer), 32'h0F);
            $display("load %h -> segs=%h", vecs[i].answer, OUT_window_segs);
            prev_segs = pick(vecs[i].exp_plain, vecs[i].exp_blank);
        end

        // Manual up with saturation at offset 4.
        for (int i = 0; i < 6; i++) begin
            press(1'b1, 1'b0, 1'b0, 6, 10);
            check("up_led", 32'(OUT_Led_Visualizer), 32'(8'h0F << ((i + 1 > 4) ? 4 : i + 1)));
        end
        check("up_segs", 32'(OUT_window_segs), 32'({7'h79, 7'h24, 7'h30, 7'h19}));
        check("up_auto", 32'(OUT_auto_mode), 32'h0);

        // New answer at offset 4 keeps the offset.
        IN_binary_answer = 32'h89EF_0567;
        IN_answer_valid = 1'b1;
        @(negedge IN_clk);
        IN_answer_valid = 1'b0;
        @(negedge IN_clk);
        check("load_off4_segs", 32'(OUT_window_segs), 32'({7'h00, 7'h10, 7'h06, 7'h0E}));
        check("load_off4_led", 32'(OUT_Led_Visualizer), 32'hF0);
        IN_binary_answer = 32'h1234_ABCD;
        IN_answer_valid = 1'b1;
        @(negedge IN_clk);
        IN_answer_valid = 1'b0;
        @(negedge IN_clk);

        press(1'b0, 1'b1, 1'b0, 6, 10);
        check("down_led", 32'(OUT_Led_Visualizer), 32'h78);
        check("down_segs", 32'(OUT_window_segs), 32'({7'h24, 7'h30, 7'h19, 7'h08}));
        press(1'b0, 1'b1, 1'b0, 6, 10);
        press(1'b0, 1'b1, 1'b0, 6, 10);
        check("down2_led", 32'(OUT_Led_Visualizer), 32'h1E);

        // Bouncy up press: 3 high, 1 low, 3 high.
        IN_up_button = 1'b1;
        repeat (3) @(negedge IN_clk);
        IN_up_button = 1'b0;
        @(negedge IN_clk);
        IN_up_button = 1'b1;
        repeat (3) @(negedge IN_clk);
        IN_up_button = 1'b0;
        repeat (12) @(negedge IN_clk);
        $display("bounce up -> led=%h", OUT_Led_Visualizer);
        check("bounce_led", 32'(OUT_Led_Visualizer), 32'h1E);
        press(1'b1, 1'b0, 1'b0, 6, 10);
        check("clean_up_led", 32'(OUT_Led_Visualizer), 32'h3C);
        press(1'b1, 1'b0, 1'b0, 20, 10);
        check("long_up_led", 32'(OUT_Led_Visualizer), 32'h78);

        for (int i = 0; i < 5; i++) press(1'b0, 1'b1, 1'b0, 6, 10);
        check("down_sat_led", 32'(OUT_Led_Visualizer), 32'h0F);
        press(1'b1, 1'b0, 1'b0, 6, 10);
        press(1'b1, 1'b1, 1'b0, 6, 10);
        check("updown_led", 32'(OUT_Led_Visualizer), 32'h1E);
        press(1'b0, 1'b1, 1'b0, 6, 10);
        check("back0_led", 32'(OUT_Led_Visualizer), 32'h0F);

        // Auto scroll: 1,2,3,4,0,1,2 every 10 cycles, then a down press at 2.
        press(1'b0, 1'b0, 1'b1, 6, 2);
        check("auto_on", 32'(OUT_auto_mode), 32'h1);
        check("auto_start_led", 32'(OUT_Led_Visualizer), 32'h0F);
        prev_led = OUT_Led_Visualizer;
        changes = 0;
        last_cyc = 0;
        for (int c = 0; c < 200 && changes < 7; c++) begin
            @(negedge IN_clk);
            if (OUT_Led_Visualizer != prev_led) begin
                check("auto_step_led", 32'(OUT_Led_Visualizer), 32'(exp_seq[changes]));
                if (changes > 0) check("auto_period", 32'(c - last_cyc), 32'd10);
                $display("auto step %0d -> led=%h at cycle %0d", changes, OUT_Led_Visualizer, c);
                last_cyc = c;
                prev_led = OUT_Led_Visualizer;
                changes++;
            end
        end
        check("auto_steps_seen", 32'(changes), 32'd7);
        press(1'b0, 1'b1, 1'b0, 6, 2);
        check("auto_down_led", 32'(OUT_Led_Visualizer), 32'h1E);
        check("auto_down_mode", 32'(OUT_auto_mode), 32'h0);
        repeat (30) @(negedge IN_clk);
        check("manual_hold_led", 32'(OUT_Led_Visualizer), 32'h1E);

        // Center plus up together: toggle to AUTO, offset held.
        press(1'b1, 1'b0, 1'b1, 6, 3);
        check("center_up_mode", 32'(OUT_auto_mode), 32'h1);
        check("center_up_led", 32'(OUT_Led_Visualizer), 32'h1E);

        // Reset while in AUTO.
        IN_reset = 1'b1;
        @(negedge IN_clk);
        check("rst_auto_mode", 32'(OUT_auto_mode), 32'h0);
        check("rst_auto_led", 32'(OUT_Led_Visualizer), 32'h0F);
        check("rst_auto_segs", 32'(OUT_window_segs), 32'(rst_segs));
        IN_reset = 1'b0;

        // Reset in the middle of a debounce leaves no pending event.
        IN_up_button = 1'b1;
        repeat (3) @(negedge IN_clk);
        IN_reset = 1'b1;
        @(negedge IN_clk);
        IN_reset = 1'b0;
        repeat (2) @(negedge IN_clk);
        IN_up_button = 1'b0;
        repeat (15) @(negedge IN_clk);
        $display("reset mid-debounce -> led=%h auto=%0b", OUT_Led_Visualizer, OUT_auto_mode);
        check("rst_deb_led", 32'(OUT_Led_Visualizer), 32'h0F);
        check("rst_deb_auto", 32'(OUT_auto_mode), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
